// File: rtl/symbol_rx_decoder_pkg.sv
// Shared definitions for the Gray-coded 2-bit symbol link: symbol width,
// receive FSM states and the Gray encode/decode pair used on both ends.
package symbol_rx_decoder_pkg;

  localparam int SYM_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  function automatic logic [SYM_WIDTH-1:0] gray_decode(input logic [SYM_WIDTH-1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  function automatic logic [SYM_WIDTH-1:0] gray_encode(input logic [SYM_WIDTH-1:0] d);
    return {d[1], d[1] ^ d[0]};
  endfunction

endpackage

// File: rtl/symbol_rx_decoder_gray_sym_decode.sv
// Combinational Gray-to-binary conversion of one received 2-bit symbol.
module gray_sym_decode
  import symbol_rx_decoder_pkg::*;
(
  input  logic [SYM_WIDTH-1:0] g,
  output logic [SYM_WIDTH-1:0] d
);

  assign d = gray_decode(g);

endmodule

// File: rtl/symbol_rx_decoder.sv
// Reassembles Gray-coded symbol frames into bytes, checks parity and symbol
// gaps, and presents good bytes through a 1-entry valid/ready buffer.
module symbol_rx_decoder
  import symbol_rx_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SYM_WIDTH-1:0]  sym_in,
  input  logic                  sym_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_parity,
  output logic                  err_timeout,
  output logic                  overrun
);

  localparam int N     = DATA_WIDTH / SYM_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N + 1) : 1;
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  state_t                 state, state_next;
  logic [SYM_WIDTH-1:0]   sym_dec;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [SYM_WIDTH-1:0]   run_xor;
  logic [CNT_W-1:0]       sym_cnt;
  logic [GAP_W-1:0]       gap_cnt;

  logic first_sym;
  logic next_sym;
  logic timeout_fire;
  logic check_ok;
  logic check_bad;

  gray_sym_decode u_dec (
    .g (sym_in),
    .d (sym_dec)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_next   = state;
    first_sym    = 1'b0;
    next_sym     = 1'b0;
    timeout_fire = 1'b0;
    check_ok     = 1'b0;
    check_bad    = 1'b0;
    case (state)
      IDLE: begin
        if (sym_valid) begin
          first_sym  = 1'b1;
          state_next = (N == 1) ? CHECK : DATA;
        end
      end
      DATA, CHECK: begin
        if (gap_cnt == GAP_W'(TIMEOUT)) begin
          // A symbol coinciding with the timeout starts a fresh frame.
          timeout_fire = 1'b1;
          if (sym_valid) begin
            first_sym  = 1'b1;
            state_next = (N == 1) ? CHECK : DATA;
          end else begin
            state_next = IDLE;
          end
        end else if (sym_valid) begin
          if (state == DATA) begin
            next_sym = 1'b1;
            if (sym_cnt == CNT_W'(N - 1)) state_next = CHECK;
          end else begin
            check_ok   = (sym_dec == run_xor);
            check_bad  = (sym_dec != run_xor);
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      run_xor <= '0;
      sym_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (first_sym) begin
        shreg   <= (shreg << SYM_WIDTH) | DATA_WIDTH'(sym_dec);
        run_xor <= sym_dec;
        sym_cnt <= CNT_W'(1);
      end else if (next_sym) begin
        shreg   <= (shreg << SYM_WIDTH) | DATA_WIDTH'(sym_dec);
        run_xor <= run_xor ^ sym_dec;
        sym_cnt <= sym_cnt + CNT_W'(1);
      end
      if (state != IDLE && !sym_valid && !timeout_fire) gap_cnt <= gap_cnt + GAP_W'(1);
      else                                              gap_cnt <= '0;
    end
  end

  // Output buffer: a good frame may replace a byte being drained this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out    <= '0;
      out_valid   <= 1'b0;
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      err_parity  <= check_bad;
      err_timeout <= timeout_fire;
      if (check_ok && (!out_valid || out_ready)) begin
        data_out  <= shreg;
        out_valid <= 1'b1;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if (check_ok)               overrun   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_symbol_rx_decoder.sv
// Directed bench for symbol_rx_decoder: hand-encoded frames for 0x5B and 0x73
// covering decode, overrun, parity, timeout, drain-and-load and async reset.
module tb_symbol_rx_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sym_in = 2'b00;
  logic       sym_valid = 1'b0;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err_parity;
  logic       err_timeout;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Gray symbols: 0x5B -> 01,01,11,10 check 01; 0x73 -> 01,10,00,10 check 01.
  logic [1:0] frame_5b [5] = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b01};
  logic [1:0] frame_73 [5] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b01};

  symbol_rx_decoder #(.DATA_WIDTH(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .sym_in      (sym_in),
    .sym_valid   (sym_valid),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_parity  (err_parity),
    .err_timeout (err_timeout),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one symbol for exactly one rising edge; returns at edge + 1.
  task automatic drive(input logic [1:0] s, input logic rdy);
    @(negedge clk);
    sym_in    = s;
    sym_valid = 1'b1;
    out_ready = rdy;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic rdy);
    @(negedge clk);
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pulses;

    #12;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_parity", 32'(err_parity), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic decode of 0x5B with consumer ready.
    for (int i = 0; i < 4; i++) drive(frame_5b[i], 1'b1);
    check("b1_pre_valid", 32'(out_valid), 32'd0);
    drive(frame_5b[4], 1'b1);
    check("b1_valid", 32'(out_valid), 32'd1);
    check("b1_data", 32'(data_out), 32'h5B);
    check("b1_parity", 32'(err_parity), 32'd0);
    check("b1_timeout", 32'(err_timeout), 32'd0);
    idle_cycle(1'b1);
    check("b1_drained", 32'(out_valid), 32'd0);
    check("b1_data_kept", 32'(data_out), 32'h5B);

    // Back-to-back frames with consumer stalled: second one overruns.
    for (int i = 0; i < 5; i++) drive(frame_5b[i], 1'b0);
    check("ov_first_valid", 32'(out_valid), 32'd1);
    check("ov_first_data", 32'(data_out), 32'h5B);
    check("ov_not_yet", 32'(overrun), 32'd0);
    for (int i = 0; i < 5; i++) drive(frame_73[i], 1'b0);
    check("ov_overrun", 32'(overrun), 32'd1);
    check("ov_data_held", 32'(data_out), 32'h5B);
    check("ov_valid_held", 32'(out_valid), 32'd1);
    idle_cycle(1'b1);
    check("ov_drain", 32'(out_valid), 32'd0);
    check("ov_sticky", 32'(overrun), 32'd1);
    do_reset();
    check("ov_cleared_by_reset", 32'(overrun), 32'd0);

    // Bad check symbol: parity pulse, buffer untouched.
    for (int i = 0; i < 4; i++) drive(frame_5b[i], 1'b1);
    drive(2'b00, 1'b1);
    check("par_pulse", 32'(err_parity), 32'd1);
    check("par_no_valid", 32'(out_valid), 32'd0);
    idle_cycle(1'b1);
    check("par_one_cycle", 32'(err_parity), 32'd0);
    for (int i = 0; i < 5; i++) drive(frame_73[i], 1'b1);
    check("par_recover_valid", 32'(out_valid), 32'd1);
    check("par_recover_data", 32'(data_out), 32'h73);
    idle_cycle(1'b1);

    // Symbol gap: two symbols then silence must abort the frame exactly once.
    drive(2'b01, 1'b1);
    drive(2'b01, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      idle_cycle(1'b1);
      if (err_timeout) pulses++;
    end
    check("to_pulses", 32'(pulses), 32'd1);
    check("to_no_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) drive(frame_73[i], 1'b1);
    check("to_recover_valid", 32'(out_valid), 32'd1);
    check("to_recover_data", 32'(data_out), 32'h73);
    check("to_recover_parity", 32'(err_parity), 32'd0);
    idle_cycle(1'b1);

    // Drain and load in the same cycle.
    for (int i = 0; i < 5; i++) drive(frame_5b[i], 1'b0);
    check("dl_first_data", 32'(data_out), 32'h5B);
    for (int i = 0; i < 4; i++) drive(frame_73[i], 1'b0);
    check("dl_still_first", 32'(data_out), 32'h5B);
    drive(frame_73[4], 1'b1);
    check("dl_valid", 32'(out_valid), 32'd1);
    check("dl_data", 32'(data_out), 32'h73);
    check("dl_no_overrun", 32'(overrun), 32'd0);

    // Asynchronous reset mid-frame with a byte still buffered.
    drive(2'b01, 1'b0);
    drive(2'b10, 1'b0);
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_data", 32'(data_out), 32'h00);
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_parity", 32'(err_parity), 32'd0);
    check("ar_timeout", 32'(err_timeout), 32'd0);
    check("ar_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) drive(frame_73[i], 1'b1);
    check("ar_clean_valid", 32'(out_valid), 32'd1);
    check("ar_clean_data", 32'(data_out), 32'h73);
    check("ar_clean_parity", 32'(err_parity), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
